// File: rtl/clk_div_param.sv
// Runtime-ratio integer clock divider with glitch-free bypass; changes apply only at period boundaries.
// Optional: define CLK_DIV_ODD_DUTY50_EN to get 50% duty on odd ratios through a falling-edge flop.
module clk_div_param #(
    parameter int RATIO_W = 8
) (
    input  logic               i_ref_clk,
    input  logic               i_rst_n,
    input  logic               i_clk_en,
    input  logic [RATIO_W-1:0] i_div_ratio,
    output logic               o_div_clk,
    output logic               o_div_active,
    output logic               o_ratio_upd
);

    // state  | meaning
    // BYPASS | o_div_clk follows i_ref_clk; waiting for enable with ratio >= 2
    // RUN    | o_div_clk driven by div_q; inputs sampled only at period boundary
    typedef enum logic {
        BYPASS = 1'b0,
        RUN    = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [RATIO_W-1:0] ratio_q, ratio_d;
    logic [RATIO_W-1:0] cnt_q, cnt_d;
    logic [RATIO_W-1:0] cnt_inc, half, last;
    logic               div_q, div_d;
    logic               upd_q, upd_d;
    logic               req;
    logic               sel;
    logic               div_out;

    assign req     = i_clk_en && (i_div_ratio >= RATIO_W'(2));
    assign half    = ratio_q >> 1;
    assign last    = ratio_q - RATIO_W'(1);
    assign cnt_inc = cnt_q + RATIO_W'(1);
    assign sel     = (state_q == RUN);

    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= BYPASS;
            ratio_q <= '0;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            upd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ratio_q <= ratio_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            upd_q   <= upd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ratio_d = ratio_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        upd_d   = 1'b0;
        case (state_q)
            BYPASS: begin
                // Entry edge lands with i_ref_clk high and div_q going high: no glitch at the mux.
                if (req) begin
                    state_d = RUN;
                    ratio_d = i_div_ratio;
                    cnt_d   = '0;
                    div_d   = 1'b1;
                    upd_d   = 1'b1;
                end
            end
            RUN: begin
                if (cnt_q != last) begin
                    cnt_d = cnt_inc;
                    div_d = (cnt_inc < half);
                end else if (req) begin
                    cnt_d   = '0;
                    div_d   = 1'b1;
                    ratio_d = i_div_ratio;
                    upd_d   = (i_div_ratio != ratio_q);
                end else begin
                    state_d = BYPASS;
                    div_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = BYPASS;
            end
        endcase
    end

`ifdef CLK_DIV_ODD_DUTY50_EN
    logic div_n;

    // Half-cycle stretch of the high phase for odd ratios.
    always_ff @(negedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            div_n <= 1'b0;
        end else begin
            div_n <= div_q;
        end
    end

    assign div_out = ratio_q[0] ? (div_q | div_n) : div_q;
`else
    assign div_out = div_q;
`endif

    assign o_div_clk    = sel ? div_out : i_ref_clk;
    assign o_div_active = sel;
    assign o_ratio_upd  = upd_q;

endmodule

// File: tb/tb_clk_div_param.sv
// Scoreboard bench for clk_div_param: a period-level model queues expected per-cycle outputs, a monitor checks both clock phases.
module tb_clk_div_param;

    localparam int RATIO_W = 8;
`ifdef CLK_DIV_ODD_DUTY50_EN
    localparam bit ODD_EN = 1'b1;
`else
    localparam bit ODD_EN = 1'b0;
`endif

    logic               i_ref_clk = 1'b0;
    logic               i_rst_n   = 1'b0;
    logic               i_clk_en  = 1'b0;
    logic [RATIO_W-1:0] i_div_ratio = '0;
    logic               o_div_clk;
    logic               o_div_active;
    logic               o_ratio_upd;

    clk_div_param #(.RATIO_W(RATIO_W)) dut (
        .i_ref_clk   (i_ref_clk),
        .i_rst_n     (i_rst_n),
        .i_clk_en    (i_clk_en),
        .i_div_ratio (i_div_ratio),
        .o_div_clk   (o_div_clk),
        .o_div_active(o_div_active),
        .o_ratio_upd (o_ratio_upd)
    );

    always #5 i_ref_clk = ~i_ref_clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    // One record per reference cycle: what the outputs must show after that rising edge.
    typedef struct packed {
        logic active;
        logic upd;
        logic div;
        logic odd;
    } rec_t;

    rec_t               per_q[$];
    rec_t               exp_q[$];
    logic [RATIO_W-1:0] m_ratio;
    logic               m_active;

    // Model: at each edge with no period pending, decide run/bypass and expand a whole period.
    always @(posedge i_ref_clk or negedge i_rst_n) begin
        int   n;
        int   h;
        logic upd;
        if (!i_rst_n) begin
            per_q.delete();
            exp_q.delete();
            m_ratio  = '0;
            m_active = 1'b0;
        end else begin
            if (per_q.size() == 0) begin
                if (i_clk_en && (i_div_ratio >= 2)) begin
                    n   = int'(i_div_ratio);
                    h   = n / 2;
                    upd = !m_active || (i_div_ratio != m_ratio);
                    for (int k = 0; k < n; k++)
                        per_q.push_back('{1'b1, (k == 0) && upd, k < h, n % 2 == 1});
                    m_ratio  = i_div_ratio;
                    m_active = 1'b1;
                end else begin
                    per_q.push_back('{1'b0, 1'b0, 1'b0, 1'b0});
                    m_active = 1'b0;
                end
            end
            exp_q.push_back(per_q.pop_front());
        end
    end

    rec_t cur;
    logic have_cur = 1'b0;
    logic prev_div = 1'b0;

    always @(posedge i_ref_clk) begin
        #1;
        if (i_rst_n) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_empty at %0t: got no expectation, expected one", $time);
            end else begin
                cur      = exp_q.pop_front();
                have_cur = 1'b1;
                check("div_active", o_div_active, cur.active);
                check("ratio_upd", o_ratio_upd, cur.upd);
                check("div_clk_hi", o_div_clk,
                      cur.active ? (cur.div | (ODD_EN && cur.odd && prev_div)) : 1'b1);
                prev_div = cur.active ? cur.div : 1'b0;
            end
        end else begin
            have_cur = 1'b0;
            prev_div = 1'b0;
        end
    end

    always @(negedge i_ref_clk) begin
        #1;
        if (i_rst_n && have_cur)
            check("div_clk_lo", o_div_clk, cur.active ? cur.div : 1'b0);
    end

    task automatic drive(input logic en, input logic [RATIO_W-1:0] r);
        @(negedge i_ref_clk);
        i_clk_en    = en;
        i_div_ratio = r;
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge i_ref_clk);
    endtask

    initial begin
        #1;
        check("rst_active", o_div_active, 1'b0);
        check("rst_upd", o_ratio_upd, 1'b0);
        check("rst_clk", o_div_clk, i_ref_clk);
        drive(1'b0, 8'd8);
        run(2);
        i_rst_n = 1'b1;
        run(10);

        drive(1'b1, 8'd4);
        run(14);
        drive(1'b1, 8'd5);
        run(16);
        drive(1'b1, 8'd6);
        run(8);
        drive(1'b1, 8'd3);
        run(12);
        drive(1'b1, 8'd4);
        run(9);
        drive(1'b0, 8'd4);
        run(10);

        drive(1'b1, 8'd1);
        run(6);
        drive(1'b1, 8'd0);
        run(6);

        drive(1'b1, 8'd255);
        run(300);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("midrst_active", o_div_active, 1'b0);
        check("midrst_upd", o_ratio_upd, 1'b0);
        check("midrst_clk_lo", o_div_clk, i_ref_clk);
        @(posedge i_ref_clk);
        #1;
        check("midrst_clk_hi", o_div_clk, i_ref_clk);
        drive(1'b0, 8'd0);
        run(2);
        i_rst_n = 1'b1;
        run(4);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0)
                drive($urandom_range(0, 7) != 0, RATIO_W'($urandom_range(0, 9)));
            else
                run(1);
        end
        drive(1'b0, 8'd0);
        run(12);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout at %0t: got no finish, expected completion", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/clk_div_param.md
Name: clk_div_param

Overview:
Parametrised integer clock divider and successor to the fixed-table divider.
- Divides i_ref_clk by any runtime ratio N in 2..2^RATIO_W-1. No lookup table.
- Bypasses to i_ref_clk when N is 0 or 1, or when the divider is disabled.
- A new ratio, enable or bypass request takes effect only at a divided-period boundary, so the output never glitches.
- Feeds the UART TX/RX sampling clocks and the other per-domain clocks in the multi-clock system.

Parameters:
RATIO_W, 8, width of the divide ratio input and of the internal counter

Ports:
i_ref_clk      input   1        reference clock; all flops clock on its rising edge (except the optional-feature flop)
i_rst_n        input   1        reset, asynchronous, active-low
i_clk_en       input   1        divider enable; 0 requests bypass
i_div_ratio    input   RATIO_W  requested divide ratio N, unsigned
o_div_clk      output  1        divided clock, or i_ref_clk when bypassed
o_div_active   output  1        1 = o_div_clk driven from the divider; 0 = bypass
o_ratio_upd    output  1        one-cycle pulse when a new ratio is loaded into the shadow register

Behaviour:
- Reset (i_rst_n=0, asynchronous):
  - ratio_q=0, cnt=0, div_q=0, sel_q=0, o_ratio_upd=0.
  - o_div_active=0 and o_div_clk=i_ref_clk.
- Run request: req = i_clk_en && (i_div_ratio >= 2), evaluated on each rising edge.
- Output mux: o_div_clk = sel_q ? div_q : i_ref_clk. The select is registered only; no combinational path from i_clk_en or i_div_ratio to o_div_clk. o_div_active = sel_q.
- Phase lengths for N = ratio_q: H = N>>1 (high cycles), L = N - H (low cycles).
  - N=2: 1/1. N=3: 1/2. N=4: 2/2. N=255: 127/128.
- Two states: BYPASS (sel_q=0) and RUN (sel_q=1).
- BYPASS, at a rising edge with req=1:
  - ratio_q<=i_div_ratio, cnt<=0, div_q<=1, sel_q<=1, o_ratio_upd<=1; go to RUN.
  - The edge lands while i_ref_clk is high and div_q goes high, so the mux hand-over is glitch-free.
- BYPASS with req=0: hold all registers; o_ratio_upd=0.
- RUN, cnt != N-1:
  - cnt<=cnt+1.
  - div_q<=1 if cnt+1 < H, else 0.
  - i_div_ratio and i_clk_en are ignored mid-period.
- RUN, cnt == N-1 (period boundary, div_q currently 0):
  - If req=1: cnt<=0, div_q<=1, ratio_q<=i_div_ratio. o_ratio_upd<=1 only if i_div_ratio != ratio_q.
  - If req=0: sel_q<=0, div_q<=0, cnt<=0; go to BYPASS. ratio_q is held.
- Latency:
  - First divided rising edge coincides with the ref edge that samples req=1.
  - A ratio change applies from the next period boundary, at most N_old ref cycles later.
- Deasserting i_clk_en mid-period: the current period always completes (low phase included) before bypass.
- Reset asserted mid-period: immediate return to the reset state. o_div_clk follows i_ref_clk combinationally; a truncated divided pulse is permitted.
- Counter width is RATIO_W; since N ≤ 2^RATIO_W-1, N-1 never wraps.

Optional Feature:
Macro: CLK_DIV_ODD_DUTY50_EN
- Defined:
  - Adds div_n, which captures div_q on the falling edge of i_ref_clk (async reset to 0).
  - When sel_q=1 and ratio_q is odd, o_div_clk = div_q | div_n. High time becomes H+0.5 ref cycles, giving exact 50% duty for odd N.
  - Even N and bypass mode are unchanged.
- Undefined: no falling-edge flop. Odd N gives H high / L low, as specified in Behaviour.

Test Plan:
- Reset, then i_clk_en=0, i_div_ratio=8 -> o_div_clk equals i_ref_clk, o_div_active=0, o_ratio_upd never pulses.
- i_clk_en=1, N=4 -> o_div_active=1 on the first edge; period 4 ref cycles, high 2 / low 2; one o_ratio_upd pulse.
- N=5, macro undefined -> high 2 / low 3 ref cycles. Macro defined -> high 2.5 / low 2.5; period 5.
- In RUN with N=6, change to N=3 at cnt=1 -> the current 6-cycle period completes; next periods are 3 cycles; o_ratio_upd pulses once at the boundary.
- In RUN with N=4, drop i_clk_en at cnt=0 -> the period finishes (2 high, 2 low), then bypass; no pulse shorter than one ref phase on o_div_clk.
- i_div_ratio=1, then 0, with i_clk_en=1 -> stays in bypass. Set N=255 -> period 255 (127 high / 128 low); assert reset mid-period -> all outputs return to reset values immediately.
